// File: rtl/regfile_sb.sv
// Two-read / one-write register file with a sequenced clear on reset,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_address,
    input  logic [ADDR_W-1:0] rt_address,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] rd_value,
    input  logic              reg_write,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] rs_value,
    output logic [DATA_W-1:0] rt_value,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_nextCount;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busyNext;
    logic              w_isRun;
    logic              w_wrValid;
    logic              w_setValid;
    logic              w_rsHit;
    logic              w_rtHit;
    logic              w_rsZero;
    logic              w_rtZero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        if (r_state == CLEAR) begin
            w_nextCount = r_count + 1'b1;
            if (r_count == LAST) begin
                w_nextState = RUN;
            end
        end
    end

    assign w_isRun    = (r_state == RUN);
    assign init_done  = w_isRun;
    assign w_wrValid  = w_isRun && reg_write && !((ZERO_REG != 0) && (rd_address == '0));
    assign w_setValid = w_isRun && busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    // The clear sequence owns the write port until it reaches the last entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_isRun) begin
                r_mem[r_count] <= '0;
            end else if (w_wrValid) begin
                r_mem[rd_address] <= rd_value;
            end
        end
    end

    // Set is applied after clear so a newly issued producer supersedes the retiring one.
    always_comb begin
        w_busyNext = r_busy;
        if (w_wrValid) begin
            w_busyNext[rd_address] = 1'b0;
        end
        if (w_setValid) begin
            w_busyNext[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (w_isRun) begin
            r_busy <= w_busyNext;
        end
    end

    assign w_rsHit  = (BYPASS != 0) && w_wrValid && (rd_address == rs_address);
    assign w_rtHit  = (BYPASS != 0) && w_wrValid && (rd_address == rt_address);
    assign w_rsZero = (ZERO_REG != 0) && (rs_address == '0);
    assign w_rtZero = (ZERO_REG != 0) && (rt_address == '0);

    always_comb begin
        rs_value = '0;
        rt_value = '0;
        rs_busy  = 1'b0;
        rt_busy  = 1'b0;
        if (w_isRun) begin
            if (w_rsHit) begin
                rs_value = rd_value;
            end else if (!w_rsZero) begin
                rs_value = r_mem[rs_address];
            end
            if (w_rtHit) begin
                rt_value = rd_value;
            end else if (!w_rtZero) begin
                rt_value = r_mem[rt_address];
            end
            rs_busy = r_busy[rs_address] && !w_rsHit;
            rt_busy = r_busy[rt_address] && !w_rtHit;
        end
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-cycle register file. It keeps the two combinational read ports and one synchronous write port. It adds:
- a sequenced synchronous clear of every register on reset;
- optional write-to-read bypass;
- a per-register busy scoreboard, so a multi-cycle datapath can stall on operands whose producer has not yet written back.

It sits between decode (read addresses, busy check) and writeback (write port) in the multi-cycle and pipelined variants of the processor.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports and clears the read busy flags combinationally.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero: never written, never busy.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; starts the clear sequence
- rs_address  in  ADDR_W  read port A address
- rt_address  in  ADDR_W  read port B address
- rd_address  in  ADDR_W  write address
- rd_value  in  DATA_W  write data
- reg_write  in  1  write enable
- busy_set  in  1  mark busy_addr as pending (producer issued)
- busy_addr  in  ADDR_W  register to mark busy
- rs_value  out  DATA_W  read data A (combinational)
- rt_value  out  DATA_W  read data B (combinational)
- rs_busy  out  1  operand A pending
- rt_busy  out  1  operand B pending
- init_done  out  1  clear sequence complete; port is usable

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
- FSM states: CLEAR, RUN.
  - rst=1 at an edge: next state CLEAR, clear counter set to 0, all busy bits set to 0, init_done=0.
  - rst=1 mid-CLEAR or mid-RUN restarts the counter at 0.
- CLEAR:
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - On the edge where counter == DEPTH-1, mem[DEPTH-1] is cleared, the state becomes RUN and init_done=1 from the next cycle.
  - Total clear time after rst deasserts: DEPTH cycles.
  - reg_write and busy_set are ignored.
  - rs_value, rt_value = 0; rs_busy, rt_busy = 0.
- RUN write:
  - At the edge, mem[rd_address] <= rd_value if reg_write.
  - With ZERO_REG=1, no write occurs when rd_address==0.
- RUN read:
  - rs_value = mem[rs_address]; likewise rt_value.
  - With ZERO_REG=1, an address of 0 reads 0 regardless of mem[0].
- Bypass (BYPASS=1):
  - If reg_write and rd_address==rs_address (and a nonzero address when ZERO_REG=1), then rs_value = rd_value in the same cycle; likewise for rt.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard (busy[DEPTH]):
  - busy_set sets busy[busy_addr] at the edge.
  - reg_write clears busy[rd_address] at the edge.
  - Same address with set and clear in the same cycle: set wins, because the new producer supersedes the old one.
  - Different addresses: both actions take effect.
  - With ZERO_REG=1, busy[0] stays 0.
- Busy outputs:
  - rs_busy = busy[rs_address], except with BYPASS=1, where it is forced to 0 when a qualifying write to rs_address occurs this cycle. Same rule for rt_busy.
- Reset values: init_done=0, all busy=0, all read outputs 0. After the CLEAR sequence, every register reads 0.
- mem is not reset in one cycle; clearing it is done only by the CLEAR sequence.

Test Plan:
- Clear sequence:
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Response: init_done=0 for exactly 32 cycles, then 1; reading all 32 addresses returns 0.
- Write/read with BYPASS=1:
  - Stimulus: reg_write=1, rd=5, value 0xDEADBEEF, with rs=5 in the same cycle.
  - Response: rs_value=0xDEADBEEF in that cycle and in the following cycle.
- Zero register:
  - Stimulus: write 0x12345678 to rd=0, then read rs=0 and rt=0.
  - Response: both read 0; rs_busy=0 after busy_set with busy_addr=0.
- Scoreboard lifecycle:
  - Stimulus: busy_set on r7, then read rs=7.
  - Response: rs_busy=1 from the next cycle. A write to r7 makes rs_busy=0 in the same cycle (BYPASS=1) and busy[7] stays clear afterwards.
- Set/clear collision:
  - Stimulus: busy_set on r9 and reg_write to r9 in the same cycle.
  - Response: the data is written, and rt_busy for rt=9 is 1 on the next cycle.
- Reset mid-operation:
  - Stimulus: write r3=0xA5, set busy on r4, assert rst for 1 cycle.
  - Response: during CLEAR, writes are ignored and outputs read 0. After 32 cycles, r3 reads 0 and r4 shows busy=0.
